// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial add/subtract controller.
// A single full-adder slice is shared across all WIDTH bits, LSB first.
// One operation takes WIDTH RUN cycles plus one DONE cycle.
module serial_add_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-2:0] sum_sh;
  logic             carry_ff;
  logic             c_into_msb;

  logic             slice_sum;
  logic             slice_cout;
  logic [WIDTH-1:0] sum_cat;
  logic             last_bit;
  logic             msb_carry_bit;

  // The one-bit adder slice fed from the operand shift register LSBs.
  assign slice_sum  = a_sh[0] ^ b_sh[0] ^ carry_ff;
  assign slice_cout = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry_ff) | (b_sh[0] & carry_ff);

  // New sum bit enters at the MSB; on the final bit this is the whole result.
  assign sum_cat       = {slice_sum, sum_sh};
  assign last_bit      = (cnt == CNT_W'(WIDTH - 1));
  assign msb_carry_bit = (cnt == CNT_W'(WIDTH - 2));

  // busy and done decode the registered state only, so start never reaches them combinationally.
  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: IDLE waits for start, RUN counts bits, DONE lasts one cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (last_bit) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: operand capture, serial shifting, carry tracking and result commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      a_sh       <= '0;
      b_sh       <= '0;
      sum_sh     <= '0;
      carry_ff   <= 1'b0;
      c_into_msb <= 1'b0;
      result     <= '0;
      carry_out  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh     <= op_a;
            b_sh     <= sub ? ~op_b : op_b;
            carry_ff <= sub;
            cnt      <= '0;
          end
        end
        RUN: begin
          a_sh     <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh     <= {1'b0, b_sh[WIDTH-1:1]};
          sum_sh   <= sum_cat[WIDTH-1:1];
          carry_ff <= slice_cout;
          cnt      <= cnt + 1'b1;
          if (msb_carry_bit) begin
            c_into_msb <= slice_cout;
          end
          if (last_bit) begin
            result    <= sum_cat;
            carry_out <= slice_cout;
            overflow  <= slice_cout ^ c_into_msb;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Testbench for serial_add_ctrl: table-driven arithmetic vectors plus
// hand-written handshake, back-to-back and mid-operation reset sequences.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         sub;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;

  int n_checks;
  int n_fail;

  logic [W-1:0] hold_result;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic [W-1:0] exp_result;
    logic         exp_cout;
    logic         exp_ovf;
    string        name;
  } vec_t;

  vec_t vecs[8];

  serial_add_ctrl #(.WIDTH(W), .CNT_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op_a      (op_a),
    .op_b      (op_b),
    .sub       (sub),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Starts one operation from IDLE and follows it to the DONE cycle.
  // Operands are scrambled right after the accepting edge; an optional
  // start pulse with other operands is injected during RUN.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                               input logic [W-1:0] er, input logic ec, input logic eo,
                               input int pulse_at, input string tag);
    int early_done;
    early_done = 0;
    op_a  = a;
    op_b  = b;
    sub   = s;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    op_a  = ~a;
    op_b  = b ^ 8'h5A;
    sub   = ~s;
    checkOutput({tag, " busy after accept"}, 32'(busy), 32'd1);
    for (int i = 1; i <= W; i++) begin
      @(posedge clk);
      #1;
      if (i < W) begin
        if (done !== 1'b0 || busy !== 1'b1) early_done++;
        if (i == pulse_at) begin
          start = 1'b1;
          op_a  = 8'h11;
          op_b  = 8'h22;
        end else begin
          start = 1'b0;
        end
        if (i == W - 1) begin
          checkOutput({tag, " result held during run"}, 32'(result), 32'(hold_result));
        end
      end else begin
        start = 1'b0;
        checkOutput({tag, " no early done"}, 32'(early_done), 32'd0);
        checkOutput({tag, " done"}, 32'(done), 32'd1);
        checkOutput({tag, " busy in done"}, 32'(busy), 32'd1);
        checkOutput({tag, " result"}, 32'(result), 32'(er));
        checkOutput({tag, " carry_out"}, 32'(carry_out), 32'(ec));
        checkOutput({tag, " overflow"}, 32'(overflow), 32'(eo));
      end
    end
    hold_result = er;
  endtask

  // One cycle after DONE the block must be idle with done cleared.
  task automatic idleStep(input string tag);
    @(posedge clk);
    #1;
    checkOutput({tag, " done cleared"}, 32'(done), 32'd0);
    checkOutput({tag, " busy cleared"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int done_seen;
    n_checks    = 0;
    n_fail      = 0;
    hold_result = '0;
    rst_n = 1'b0;
    start = 1'b0;
    op_a  = '0;
    op_b  = '0;
    sub   = 1'b0;

    vecs[0] = '{8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 1'b0, "add 3C+0F"};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "add FF+01"};
    vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, "add 7F+01"};
    vecs[3] = '{8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, "sub 05-07"};
    vecs[4] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, "sub 80-01"};
    vecs[5] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, "sub 00-00"};
    vecs[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, "add 80+80"};
    vecs[7] = '{8'h01, 8'h80, 1'b1, 8'h81, 1'b0, 1'b1, "sub 01-80"};

    #12;
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset result", 32'(result), 32'd0);
    checkOutput("reset carry_out", 32'(carry_out), 32'd0);
    checkOutput("reset overflow", 32'(overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int v = 0; v < 8; v++) begin
      applyStimulus(vecs[v].a, vecs[v].b, vecs[v].s, vecs[v].exp_result,
                    vecs[v].exp_cout, vecs[v].exp_ovf, 0, vecs[v].name);
      idleStep(vecs[v].name);
    end

    // start pulsed mid-run with other operands must be ignored and not queued.
    applyStimulus(8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 1'b0, 3, "ignored start");
    idleStep("ignored start");
    @(posedge clk);
    #1;
    checkOutput("ignored start not queued", 32'(busy), 32'd0);

    // Back-to-back: second start in the first IDLE cycle after DONE.
    applyStimulus(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0, "b2b first");
    @(posedge clk);
    #1;
    checkOutput("b2b idle gap", 32'(busy), 32'd0);
    applyStimulus(8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, 0, "b2b second");
    idleStep("b2b second");

    // Reset asserted with the bit counter at 3.
    op_a  = 8'h3C;
    op_b  = 8'h0F;
    sub   = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset busy", 32'(busy), 32'd0);
    checkOutput("midreset done", 32'(done), 32'd0);
    checkOutput("midreset result", 32'(result), 32'd0);
    checkOutput("midreset carry_out", 32'(carry_out), 32'd0);
    checkOutput("midreset overflow", 32'(overflow), 32'd0);
    done_seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) done_seen++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) done_seen++;
    end
    checkOutput("midreset no done pulse", 32'(done_seen), 32'd0);
    checkOutput("midreset result still clear", 32'(result), 32'd0);
    hold_result = '0;
    applyStimulus(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 0, "after reset");
    idleStep("after reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
